data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the core's data memory port, the memory-side end of the valid/ready interface the core drives. Captures one request per handshake, models a fixed access latency, performs a word read or write on an internal synchronous RAM, and pulses ready for one cycle when the access completes. It sits in the top level between the core's data memory outputs and inputs.

## Interface
- XLEN, 32: data and address width.
- DEPTH_LOG2, 10: log2 of RAM depth in XLEN-bit words; RAM holds 2^DEPTH_LOG2 words.
- LATENCY, 2: cycles from request capture to ready; legal range 1..15, elaborate-time error outside it.

- clock_in  input  1  single clock; all state changes on its rising edge.
- reset_in  input  1  reset; synchronous and active-high.
- data_mem_valid_in  input  1  request present.
- data_mem_write_in  input  1  1 = write, 0 = read; sampled with valid.
- data_mem_addr_in  input  XLEN  byte address; word index = addr[DEPTH_LOG2+1:2].
- data_mem_data_in  input  XLEN  write data from core.
- data_mem_data_out  output  XLEN  read data to core.
- data_mem_ready_out  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: valid_in=1 at an edge -> capture addr, write, wdata into holding registers; load latency counter with LATENCY-1; go BUSY. valid_in=0 -> stay IDLE.
- BUSY: counter nonzero -> decrement, stay BUSY. Counter zero -> perform access on captured request, assert ready_out, go RESP.
- Access: write -> RAM[index] <= captured wdata, data_out unchanged. Read -> data_out <= RAM[index] (value before any write in that same edge; no concurrent write is possible).
- RESP (ready_out=1 for exactly this cycle): valid_in=1 at the next edge -> capture new request, go BUSY (back-to-back); else go IDLE. ready_out deasserts at that edge in both cases.
- Core protocol: hold valid/write/addr/data stable from assertion until ready_out is seen; in the ready cycle either drop valid or present the next request.
- Inputs changing or valid dropping during BUSY: ignored; captured transaction completes, no abort.
- addr[1:0] ignored (word access only, no byte enables); address bits above DEPTH_LOG2+1 ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
- data_out holds last read result until the next read completes.
- RAM contents are not cleared by reset; only control and output registers are.

## Timing
- Reset values: data_mem_ready_out=0, data_mem_data_out=0, state IDLE, counter 0, holding registers 0.
- Reset at any edge overrides everything: return to IDLE; a pending write not yet committed is discarded; a write committing at the same edge as reset_in=1 is discarded.
- Request sampled at edge E0 -> RAM update / data_out load and ready_out rise at edge E0+LATENCY; ready_out falls at E0+LATENCY+1.
- LATENCY=1: BUSY lasts one cycle, ready at E0+1.
- Throughput: back-to-back requests complete every LATENCY+1 cycles; with idle gaps, every LATENCY+2 or more.
- Read-after-write to same word, back-to-back: read returns the new data.
- All outputs registered; no combinational path from any input to any output.

## Test plan
- Reset: hold reset_in=1 for 3 edges with valid_in=1 -> ready_out=0, data_out=0 throughout, no RAM write.
- Single write then read, LATENCY=2: write 0xDEADBEEF to 0x0000_0010 at E0 -> ready high only during E2..E3; read 0x10 at E3 -> ready at E5, data_out=0xDEADBEEF.
- Back-to-back: write 0x1 to 0x20, keep valid high in ready cycle with read of 0x20 -> second ready exactly LATENCY+1 cycles after first, data_out=0x1.
- Aliasing/misalignment, DEPTH_LOG2=10: write 0xA5A5A5A5 to 0x0000_1004; read 0x0000_0007 -> 0xA5A5A5A5.
- Mid-transaction changes: after capturing write 0x11 to 0x30, switch addr to 0x40 and drop valid in BUSY -> ready still pulses at E0+LATENCY; read 0x30 = 0x11, read 0x40 unchanged.
- Reset mid-BUSY: capture write 0x55 to 0x50, assert reset_in one edge before completion -> no ready pulse, read 0x50 returns prior value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: captures one valid/ready request,
// waits a fixed latency, performs a word access on an internal RAM and pulses ready.
module data_mem_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            data_mem_valid_in,
    input  logic            data_mem_write_in,
    input  logic [XLEN-1:0] data_mem_addr_in,
    input  logic [XLEN-1:0] data_mem_data_in,
    output logic [XLEN-1:0] data_mem_data_out,
    output logic            data_mem_ready_out
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : gen_latency_check
        $error("data_mem_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  write_q, write_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic [XLEN-1:0]       data_out_q;
    logic                  capture;
    logic                  ram_we;
    logic                  ram_re;
    logic [XLEN-1:0]       ram [DEPTH];

    // Byte-offset and high address bits are deliberately dropped: word access, aliased.
    logic [DEPTH_LOG2-1:0] addr_idx;
    logic                  unused_addr_bits;
    assign addr_idx         = data_mem_addr_in[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{data_mem_addr_in[XLEN-1:DEPTH_LOG2+2], data_mem_addr_in[1:0]};

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch can be inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        capture = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        unique case (state_q)
            IDLE: capture = data_mem_valid_in;
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    ram_we  = write_q;
                    ram_re  = !write_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                capture = data_mem_valid_in;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A request seen in IDLE or in the ready cycle is latched; later input changes are ignored.
        if (capture) begin
            idx_d   = addr_idx;
            write_d = data_mem_write_in;
            wdata_d = data_mem_data_in;
            cnt_d   = LAT_M1;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clock_in) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset_in) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            if (ram_re) begin
                data_out_q <= ram[idx_q];
            end
        end
    end

    // NOTE: the RAM array has no reset; only control and output registers are cleared.
    always_ff @(posedge clock_in) begin
        if (ram_we && !reset_in) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign data_mem_data_out  = data_out_q;
    assign data_mem_ready_out = ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array model predicts data_out and
// the completion cycle of every request; a negedge monitor compares on each ready pulse.
module tb_data_mem_responder;

    localparam int XLEN       = 32;
    localparam int DEPTH_LOG2 = 10;
    localparam int LAT        = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       tag;
    } sb_entry_t;

    logic            clk = 1'b0;
    logic            reset_in;
    logic            valid;
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] data_out;
    logic            ready_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          prev_ready = 1'b0;
    sb_entry_t   sb[$];
    logic [31:0] model [int];
    logic [31:0] last_rd = 32'h0;

    data_mem_responder #(
        .XLEN      (XLEN),
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LAT)
    ) dut (
        .clock_in          (clk),
        .reset_in          (reset_in),
        .data_mem_valid_in (valid),
        .data_mem_write_in (write),
        .data_mem_addr_in  (addr),
        .data_mem_data_in  (wdata),
        .data_mem_data_out (data_out),
        .data_mem_ready_out(ready_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding prediction and last one cycle.
    always @(negedge clk) begin
        if (prev_ready) check("ready_fall", 32'(ready_out), 32'h0);
        if (ready_out) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 32'(ready_out), 32'h0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                check({e.tag, "_data"}, data_out, e.data);
                check({e.tag, "_time"}, 32'(cyc), 32'(e.due));
            end
        end
        prev_ready = ready_out;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one request (called just after a posedge, DUT in IDLE or RESP) and wait for ready.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input string tag, input bit keep, input bit mangle);
        sb_entry_t e;
        int        idx;
        bit        seen;
        idx = int'((a >> 2) % DEPTH);
        if (w) begin
            model[idx] = d;
        end else begin
            last_rd = model.exists(idx) ? model[idx] : 32'hxxxx_xxxx;
        end
        e.data = last_rd;
        e.due  = cyc + 1 + LAT;
        e.tag  = tag;
        sb.push_back(e);
        valid = 1'b1;
        write = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (mangle) begin
            valid = 1'b0;
            addr  = 32'h0000_0040;
            wdata = 32'hEEEE_EEEE;
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready_out) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'(ready_out), 32'h1);
            sb.delete();
        end
        if (!keep) valid = 1'b0;
    endtask

    task automatic hold_reset(input string tag);
        reset_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check({tag, "_ready"}, 32'(ready_out), 32'h0);
            check({tag, "_data"}, data_out, 32'h0);
        end
        reset_in = 1'b0;
        valid    = 1'b0;
        last_rd  = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_in = 1'b1;
        valid    = 1'b1;
        write    = 1'b1;
        addr     = 32'h0000_0010;
        wdata    = 32'hFFFF_FFFF;
        hold_reset("reset");
        idle(1);

        // Single write then read
        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr_10", 1'b0, 1'b0);
        xact(1'b0, 32'h0000_0010, 32'h0, "rd_10", 1'b0, 1'b0);
        idle(2);

        // Back-to-back write/read of the same word
        xact(1'b1, 32'h0000_0020, 32'h0000_0001, "b2b_wr", 1'b1, 1'b0);
        xact(1'b0, 32'h0000_0020, 32'h0, "b2b_rd", 1'b0, 1'b0);
        idle(1);

        // Aliasing and misaligned address
        xact(1'b1, 32'h0000_1004, 32'hA5A5_A5A5, "alias_wr", 1'b0, 1'b0);
        xact(1'b0, 32'h0000_0007, 32'h0, "alias_rd", 1'b0, 1'b0);
        idle(1);

        // Inputs changing during BUSY
        xact(1'b1, 32'h0000_0040, 32'h0000_0099, "pre_40", 1'b0, 1'b0);
        xact(1'b1, 32'h0000_0030, 32'h0000_0011, "mangle_wr", 1'b0, 1'b1);
        xact(1'b0, 32'h0000_0030, 32'h0, "mangle_rd30", 1'b1, 1'b0);
        xact(1'b0, 32'h0000_0040, 32'h0, "mangle_rd40", 1'b0, 1'b0);
        idle(1);

        // Reset held with a write request present: no write, outputs cleared
        xact(1'b1, 32'h0000_0060, 32'h0000_0077, "pre_60", 1'b0, 1'b0);
        xact(1'b0, 32'h0000_0010, 32'h0, "pre_rst_rd", 1'b0, 1'b0);
        valid = 1'b1;
        write = 1'b1;
        addr  = 32'h0000_0060;
        wdata = 32'h0000_0BAD;
        hold_reset("reset_hold");
        idle(1);
        xact(1'b0, 32'h0000_0060, 32'h0, "rd_60", 1'b0, 1'b0);
        idle(1);

        // Reset one edge before completion and exactly at the completion edge
        xact(1'b1, 32'h0000_0050, 32'h0000_0033, "pre_50", 1'b0, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            valid = 1'b1;
            write = 1'b1;
            addr  = 32'h0000_0050;
            wdata = 32'h0000_0055;
            @(posedge clk);
            #1;
            valid = 1'b0;
            repeat (k - 1) begin
                @(posedge clk);
                #1;
            end
            reset_in = 1'b1;
            @(posedge clk);
            #1;
            reset_in = 1'b0;
            last_rd  = 32'h0;
            check("rst_busy_data", data_out, 32'h0);
            repeat (3) begin
                @(posedge clk);
                #1;
                check("rst_busy_noready", 32'(ready_out), 32'h0);
            end
            xact(1'b0, 32'h0000_0050, 32'h0, "rst_busy_rd50", 1'b0, 1'b0);
            idle(1);
        end

        // Randomised mix over eight words with aliased/misaligned addresses
        for (int i = 0; i < 8; i++) begin
            xact(1'b1, 32'((256 + i) << 2), $urandom, "rnd_init", 1'b1, 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(256, 263);
            a = 32'(r << 2) | 32'($urandom_range(0, 3)) | 32'($urandom_range(0, 7) << 12);
            xact(1'($urandom_range(0, 1)), a, $urandom, "rnd", 1'($urandom_range(0, 1)), 1'b0);
            if (valid == 1'b0) idle($urandom_range(0, 2));
        end
        valid = 1'b0;
        idle(4);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
